// File: rtl/raw_to_rgb_demosaic.sv
// RGGB Bayer RAW to parallel RGB demosaic: one previous-row line buffer,
// each horizontal pixel pair pulls its missing colours from the row above.

module raw_to_rgb_demosaic_pair #(
  parameter int C_BPP = 8
) (
  input  logic             par_i,
  input  logic             pv_i,
  input  logic [C_BPP-1:0] c0_i,
  input  logic [C_BPP-1:0] c1_i,
  input  logic [C_BPP-1:0] p0_i,
  input  logic [C_BPP-1:0] p1_i,
  output logic [C_BPP-1:0] r_o,
  output logic [C_BPP-1:0] g_o,
  output logic [C_BPP-1:0] b_o
);
  logic [C_BPP-1:0] g_cur, g_prv;
  logic [C_BPP:0]   g_sum;

  always_comb begin
    r_o   = '0;
    b_o   = '0;
    g_cur = par_i ? c0_i : c1_i;
    g_prv = par_i ? p1_i : p0_i;
    if (!par_i) begin
      r_o = c0_i;
      b_o = pv_i ? p1_i : '0;
    end else begin
      r_o = pv_i ? p0_i : '0;
      b_o = c1_i;
    end
    // one extra bit keeps the rounded average from wrapping
    g_sum = (C_BPP+1)'(g_cur) + (C_BPP+1)'(g_prv) + (C_BPP+1)'(1);
    g_o   = pv_i ? g_sum[C_BPP:1] : g_cur;
  end
endmodule

module raw_to_rgb_demosaic #(
  parameter int C_BPP         = 8,
  parameter int C_PORT_NUM    = 4,
  parameter int C_RAW_BIT_NUM = 12,
  parameter     C_RAW_MODE    = "RGGB",
  parameter int C_MAX_BEATS   = 1024
) (
  input  logic                              VID_CLK,
  input  logic                              VID_RSTN,
  input  logic                              S_VS,
  input  logic                              S_HS,
  input  logic                              S_DE,
  input  logic [C_RAW_BIT_NUM*C_PORT_NUM-1:0] S_RAW,
  output logic                              M_VS,
  output logic                              M_HS,
  output logic                              M_DE,
  output logic [C_BPP*C_PORT_NUM-1:0]       M_R,
  output logic [C_BPP*C_PORT_NUM-1:0]       M_G,
  output logic [C_BPP*C_PORT_NUM-1:0]       M_B
);
  localparam int W        = C_RAW_BIT_NUM * C_PORT_NUM;
  localparam int AW       = (C_MAX_BEATS > 1) ? $clog2(C_MAX_BEATS) : 1;
  localparam int PAIRS    = C_PORT_NUM / 2;
  localparam int STAGES   = 2;
  localparam logic [AW-1:0] ADDR_MAX = AW'(C_MAX_BEATS - 1);
  // every Bayer order decodes as RGGB
  localparam logic MODE_RGGB = (C_RAW_MODE == "RGGB");

  logic          vs_prev_q, de_prev_q;
  logic          parity_q, parity_d, pv_q, pv_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          vs_rise, de_fall;

  logic [W-1:0]  lbuf [C_MAX_BEATS];

  logic [STAGES:1] vld_pipe_q, vs_pipe_q, hs_pipe_q;
  logic [W-1:0]    raw1_q, rd1_q;
  logic            par1_q, pv1_q;

  logic [C_PORT_NUM-1:0][C_BPP-1:0] r_d, g_d, b_d, r_q, g_q, b_q;
  logic [PAIRS-1:0][C_BPP-1:0]      pr, pg, pb;

  assign vs_rise = S_VS & ~vs_prev_q;
  assign de_fall = ~S_DE & de_prev_q;

  always_comb begin
    parity_d = parity_q;
    pv_d     = pv_q;
    addr_d   = addr_q;
    if (vs_rise) begin
      parity_d = 1'b0;
      pv_d     = 1'b0;
      addr_d   = '0;
    end else if (de_fall) begin
      parity_d = ~parity_q;
      pv_d     = 1'b1;
      addr_d   = '0;
    end else if (S_DE && addr_q != ADDR_MAX) begin
      addr_d   = addr_q + 1'b1;
    end
  end

  always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
    if (!VID_RSTN) begin
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
      parity_q  <= 1'b0;
      pv_q      <= 1'b0;
      addr_q    <= '0;
    end else begin
      vs_prev_q <= S_VS;
      de_prev_q <= S_DE;
      parity_q  <= parity_d;
      pv_q      <= pv_d;
      addr_q    <= addr_d;
    end
  end

  // contents are don't-care until written, so no reset
  always_ff @(posedge VID_CLK) begin
    if (S_DE) lbuf[addr_q] <= S_RAW;
  end

  always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
    if (!VID_RSTN) begin
      vld_pipe_q <= '0;
      vs_pipe_q  <= '0;
      hs_pipe_q  <= '0;
      raw1_q     <= '0;
      rd1_q      <= '0;
      par1_q     <= 1'b0;
      pv1_q      <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], S_DE};
      vs_pipe_q  <= {vs_pipe_q[1], S_VS};
      hs_pipe_q  <= {hs_pipe_q[1], S_HS};
      raw1_q     <= S_RAW;
      rd1_q      <= lbuf[addr_q];
      par1_q     <= parity_q;
      pv1_q      <= pv_q;
    end
  end

  for (genvar i = 0; i < PAIRS; i++) begin : g_pair
    raw_to_rgb_demosaic_pair #(.C_BPP(C_BPP)) u_pair (
      .par_i (par1_q),
      .pv_i  (pv1_q),
      .c0_i  (raw1_q[(2*i+1)*C_RAW_BIT_NUM-1 -: C_BPP]),
      .c1_i  (raw1_q[(2*i+2)*C_RAW_BIT_NUM-1 -: C_BPP]),
      .p0_i  (rd1_q[(2*i+1)*C_RAW_BIT_NUM-1 -: C_BPP]),
      .p1_i  (rd1_q[(2*i+2)*C_RAW_BIT_NUM-1 -: C_BPP]),
      .r_o   (pr[i]),
      .g_o   (pg[i]),
      .b_o   (pb[i])
    );
    assign r_d[2*i]   = pr[i];
    assign r_d[2*i+1] = pr[i];
    assign g_d[2*i]   = pg[i];
    assign g_d[2*i+1] = pg[i];
    assign b_d[2*i]   = pb[i];
    assign b_d[2*i+1] = pb[i];
  end

  always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
    if (!VID_RSTN) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (vld_pipe_q[1]) begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end else begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end
  end

  assign M_VS = vs_pipe_q[STAGES];
  assign M_HS = hs_pipe_q[STAGES];
  assign M_DE = vld_pipe_q[STAGES];
  assign M_R  = r_q;
  assign M_G  = g_q;
  assign M_B  = b_q;

  // raw LSBs are intentionally dropped
  logic unused_bits;
  assign unused_bits = ^{raw1_q, rd1_q, MODE_RGGB};
endmodule

// File: tb/tb_raw_to_rgb_demosaic.sv
// Randomised bench for raw_to_rgb_demosaic against a row-level Bayer model.

module tb_raw_to_rgb_demosaic;
  localparam int MB = 16;

  logic        VID_CLK = 1'b0;
  logic        VID_RSTN;
  logic        S_VS, S_HS, S_DE;
  logic [47:0] S_RAW;
  logic        M_VS, M_HS, M_DE;
  logic [31:0] M_R, M_G, M_B;

  raw_to_rgb_demosaic #(.C_BPP(8), .C_PORT_NUM(4), .C_RAW_BIT_NUM(12),
                        .C_RAW_MODE("RGGB"), .C_MAX_BEATS(MB)) dut (
    .VID_CLK(VID_CLK), .VID_RSTN(VID_RSTN), .S_VS(S_VS), .S_HS(S_HS),
    .S_DE(S_DE), .S_RAW(S_RAW), .M_VS(M_VS), .M_HS(M_HS), .M_DE(M_DE),
    .M_R(M_R), .M_G(M_G), .M_B(M_B));

  always #5 VID_CLK = ~VID_CLK;

  typedef struct packed {
    logic vs, hs, de;
    logic [31:0] r, g, b;
  } out_t;

  int n_chk = 0, n_pass = 0;
  out_t obs_log[$], exp_log[$];
  out_t exp_prev;

  // frame-level model: row parity, first-row flag, beat index in row, prev-row store
  bit          m_vs, m_de, m_par, m_pv;
  int          m_beat;
  logic [47:0] m_buf [MB];

  function automatic logic [47:0] pair_word(input logic [11:0] a, input logic [11:0] b);
    return {b, a, b, a};
  endfunction

  task automatic model_reset();
    m_vs = 0; m_de = 0; m_par = 0; m_pv = 0; m_beat = 0;
    exp_prev = '0;
  endtask

  task automatic model_step(input logic vs, input logic hs, input logic de,
                            input logic [47:0] raw, output out_t e);
    int ea;
    logic [47:0] pw;
    logic [7:0] c0, c1, p0, p1, r, g, b, gc, gp;
    e = '0; e.vs = vs; e.hs = hs; e.de = de;
    ea = (m_beat < MB) ? m_beat : MB - 1;
    pw = m_buf[ea];
    if (de) begin
      for (int k = 0; k < 2; k++) begin
        c0 = raw[24*k+4 +: 8];  c1 = raw[24*k+16 +: 8];
        p0 = pw[24*k+4 +: 8];   p1 = pw[24*k+16 +: 8];
        if (!m_par) begin
          r = c0; gc = c1; gp = p0; b = m_pv ? p1 : 8'h00;
        end else begin
          b = c1; gc = c0; gp = p1; r = m_pv ? p0 : 8'h00;
        end
        g = m_pv ? 8'((int'(gc) + int'(gp) + 1) / 2) : gc;
        e.r[16*k +: 16] = {r, r};
        e.g[16*k +: 16] = {g, g};
        e.b[16*k +: 16] = {b, b};
      end
      m_buf[ea] = raw;
      m_beat++;
    end
    if (vs && !m_vs) begin
      m_par = 0; m_pv = 0; m_beat = 0;
    end else if (!de && m_de) begin
      m_par = !m_par; m_pv = 1; m_beat = 0;
    end
    m_vs = vs; m_de = de;
  endtask

  task automatic drive(input logic vs, input logic hs, input logic de, input logic [47:0] raw);
    out_t e, o;
    S_VS = vs; S_HS = hs; S_DE = de; S_RAW = raw;
    model_step(vs, hs, de, raw, e);
    @(posedge VID_CLK); #1;
    o = {M_VS, M_HS, M_DE, M_R, M_G, M_B};
    obs_log.push_back(o);
    exp_log.push_back(exp_prev);
    exp_prev = e;
  endtask

  task automatic vs_pulse();
    drive(1, 0, 0, '0); drive(1, 0, 0, '0);
    drive(0, 0, 0, '0); drive(0, 0, 0, '0);
  endtask

  task automatic row(input int beats, input bit rnd, input logic [47:0] w,
                     input bit vs_at_end, output logic [47:0] lastw);
    logic [47:0] d;
    drive(0, 1, 0, '0);
    drive(0, 0, 0, '0);
    d = w;
    for (int i = 0; i < beats; i++) begin
      if (rnd) d = {16'($urandom), $urandom};
      drive(0, 0, 1, d);
    end
    lastw = d;
    drive(vs_at_end, 0, 0, '0);
    if (vs_at_end) drive(1, 0, 0, '0);
    drive(0, 0, 0, '0);
    drive(0, 0, 0, '0);
  endtask

  task automatic test_reset();
    VID_RSTN = 1'b0; model_reset();
    for (int i = 0; i < 4; i++) begin
      S_VS = 1'($urandom); S_HS = 1'($urandom); S_DE = 1'b1;
      S_RAW = {16'($urandom), $urandom};
      @(negedge VID_CLK);
      n_chk++;
      if ({M_VS, M_HS, M_DE, M_R, M_G, M_B} !== '0)
        $display("FAIL reset_hold[%0d] got %h exp 0", i, {M_VS, M_HS, M_DE, M_R, M_G, M_B});
      else n_pass++;
    end
    @(posedge VID_CLK); #1;
    VID_RSTN = 1'b1;
    S_VS = 0; S_HS = 0; S_DE = 0; S_RAW = '0;
    obs_log.delete(); exp_log.delete();
    drive(0, 0, 0, '0);
    n_chk++;
    if ({M_VS, M_HS, M_DE, M_R, M_G, M_B} !== '0)
      $display("FAIL reset_after got %h exp 0", {M_VS, M_HS, M_DE, M_R, M_G, M_B});
    else n_pass++;
  endtask

  task automatic test_latency();
    obs_log.delete(); exp_log.delete();
    for (int i = 0; i < 30; i++)
      drive(1'($urandom), 1'($urandom), 1'($urandom), {16'($urandom), $urandom});
    drive(0, 0, 0, '0);
    for (int i = 0; i < obs_log.size(); i++) begin
      n_chk++;
      if ({obs_log[i].vs, obs_log[i].hs, obs_log[i].de} !== {exp_log[i].vs, exp_log[i].hs, exp_log[i].de})
        $display("FAIL latency_sync[%0d] got %b exp %b", i,
                 {obs_log[i].vs, obs_log[i].hs, obs_log[i].de}, {exp_log[i].vs, exp_log[i].hs, exp_log[i].de});
      else n_pass++;
    end
  endtask

  task automatic test_rows();
    logic [47:0] lw;
    int st[3], rix;
    logic [7:0] er[3], eg[3], eb[3];
    er = '{8'hA0, 8'hA0, 8'hFF}; eg = '{8'h50, 8'h51, 8'hA9}; eb = '{8'h00, 8'h30, 8'h30};
    vs_pulse();
    obs_log.delete(); exp_log.delete();
    st[0] = 0;                row(8, 0, pair_word(12'hA00, 12'h500), 0, lw);
    st[1] = obs_log.size();   row(8, 0, pair_word(12'h520, 12'h300), 0, lw);
    st[2] = obs_log.size();   row(8, 0, {4{12'hFF0}}, 0, lw);
    for (int i = 0; i < obs_log.size(); i++) begin
      n_chk++;
      if (obs_log[i] !== exp_log[i])
        $display("FAIL rows_model[%0d] got %h exp %h", i, obs_log[i], exp_log[i]);
      else n_pass++;
      rix = (i >= st[2]) ? 2 : (i >= st[1]) ? 1 : 0;
      if (obs_log[i].de) begin
        n_chk++;
        if ({obs_log[i].r, obs_log[i].g, obs_log[i].b} !== {{4{er[rix]}}, {4{eg[rix]}}, {4{eb[rix]}}})
          $display("FAIL rows_const%0d[%0d] got %h exp %h", rix, i,
                   {obs_log[i].r, obs_log[i].g, obs_log[i].b}, {{4{er[rix]}}, {4{eg[rix]}}, {4{eb[rix]}}});
        else n_pass++;
      end
    end
  endtask

  task automatic test_frame_boundary();
    logic [47:0] lw;
    int st[3], rix;
    vs_pulse();
    obs_log.delete(); exp_log.delete();
    st[0] = 0;                row(8, 0, pair_word(12'hA00, 12'h500), 0, lw);
    st[1] = obs_log.size();   row(8, 0, pair_word(12'h520, 12'h300), 1, lw);
    st[2] = obs_log.size();   row(8, 0, pair_word(12'hA00, 12'h500), 0, lw);
    for (int i = 0; i < obs_log.size(); i++) begin
      n_chk++;
      if (obs_log[i] !== exp_log[i])
        $display("FAIL frame_model[%0d] got %h exp %h", i, obs_log[i], exp_log[i]);
      else n_pass++;
      rix = (i >= st[2]) ? 2 : (i >= st[1]) ? 1 : 0;
      if (obs_log[i].de && rix != 1) begin
        n_chk++;
        if ({obs_log[i].r, obs_log[i].g, obs_log[i].b} !== {32'hA0A0A0A0, 32'h50505050, 32'h0})
          $display("FAIL frame_first_row%0d[%0d] got %h exp %h", rix, i,
                   {obs_log[i].r, obs_log[i].g, obs_log[i].b}, {32'hA0A0A0A0, 32'h50505050, 32'h0});
        else n_pass++;
      end
    end
  endtask

  task automatic test_overlength();
    logic [47:0] lw0, lw1, lw2;
    int st2, nde;
    vs_pulse();
    obs_log.delete(); exp_log.delete();
    row(MB, 1, '0, 0, lw0);
    row(MB + 3, 1, '0, 0, lw1);
    st2 = obs_log.size();
    row(MB, 1, '0, 0, lw2);
    nde = 0;
    for (int i = 0; i < obs_log.size(); i++) begin
      n_chk++;
      if (obs_log[i] !== exp_log[i])
        $display("FAIL overlen_model[%0d] got %h exp %h", i, obs_log[i], exp_log[i]);
      else n_pass++;
      if (i >= st2 && obs_log[i].de) begin
        if (nde == MB - 1) begin
          n_chk++;
          if (obs_log[i].b[7:0] !== lw1[23:16])
            $display("FAIL overlen_last_entry got %h exp %h", obs_log[i].b[7:0], lw1[23:16]);
          else n_pass++;
        end
        nde++;
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [47:0] lw;
    vs_pulse();
    obs_log.delete(); exp_log.delete();
    row(6, 1, '0, 0, lw);
    drive(0, 1, 0, '0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, {16'($urandom), $urandom});
    #2 VID_RSTN = 1'b0;
    #1;
    n_chk++;
    if ({M_VS, M_HS, M_DE, M_R, M_G, M_B} !== '0)
      $display("FAIL async_reset got %h exp 0", {M_VS, M_HS, M_DE, M_R, M_G, M_B});
    else n_pass++;
    @(posedge VID_CLK); #1;
    VID_RSTN = 1'b1;
    model_reset();
    obs_log.delete(); exp_log.delete();
    for (int i = 0; i < 5; i++) drive(0, 0, 1, {16'($urandom), $urandom});
    drive(0, 0, 0, '0);
    drive(0, 0, 0, '0);
    row(5, 1, '0, 0, lw);
    for (int i = 0; i < obs_log.size(); i++) begin
      n_chk++;
      if (obs_log[i] !== exp_log[i])
        $display("FAIL midframe_model[%0d] got %h exp %h", i, obs_log[i], exp_log[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] lw;
    vs_pulse();
    obs_log.delete(); exp_log.delete();
    for (int r = 0; r < 5; r++) row(10, 1, '0, 0, lw);
    for (int i = 0; i < obs_log.size(); i++) begin
      n_chk++;
      if (obs_log[i] !== exp_log[i])
        $display("FAIL b2b_model[%0d] got %h exp %h", i, obs_log[i], exp_log[i]);
      else n_pass++;
    end
  endtask

  initial begin
    S_VS = 0; S_HS = 0; S_DE = 0; S_RAW = '0; VID_RSTN = 1'b0;
    for (int i = 0; i < MB; i++) m_buf[i] = '0;
    test_reset();
    test_latency();
    test_rows();
    test_frame_boundary();
    test_overlength();
    test_reset_midframe();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
